// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared fetch constants, fetch-state enum and PC helper
package cpu_defs_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    BUF   = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - one-entry instruction/PC4 skid buffer for fetches that land under stall
module fetch_skid (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        unload,
  input  logic [31:0] ir_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] ir,
  output logic [31:0] pc4,
  output logic        full
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir   <= 32'h0;
      pc4  <= 32'h0;
      full <= 1'b0;
    end else if (load) begin
      ir   <= ir_in;
      pc4  <= pc4_in;
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC, imem req/ack fetch, IF/ID register, delay-slot redirect
// Optional misaligned-fetch exception under FETCH_ALIGN_CHK_EN.
module fetch_unit
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] NPC_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_F,
  output logic [31:0] IR_D,
  output logic [31:0] PC4_D,
  output logic        valid_D,
  output logic        exc_adel_D
);

  fetch_state_t state, state_n;
  logic [31:0]  pc_n, tgt_q, tgt_n, pc_plus4, adv_pc;
  logic         pend, pend_n;
  logic         req, ack, redir, misalign;
  logic         ifid_ld, bubble;
  logic [31:0]  ifid_ir, ifid_pc4;
  logic         skid_load, skid_unload, skid_full;
  logic [31:0]  skid_ir, skid_pc4;
`ifdef FETCH_ALIGN_CHK_EN
  logic         ifid_exc;
  assign misalign = (PC_F[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign imem_req  = req && reset_n;
  assign imem_addr = {PC_F[31:2], 2'b00};
  assign ack       = imem_req && imem_ack;
  assign redir     = redirect_i && !stall_i;
  assign pc_plus4  = pc_inc(PC_F);
  // A fresh redirect wins; otherwise a redirect parked during a slow delay-slot fetch.
  assign adv_pc    = redir ? NPC_i : (pend ? tgt_q : pc_plus4);

  fetch_skid u_skid (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (skid_load),
    .unload (skid_unload),
    .ir_in  (imem_rdata),
    .pc4_in (pc_plus4),
    .ir     (skid_ir),
    .pc4    (skid_pc4),
    .full   (skid_full)
  );

  always_comb begin
    state_n     = state;
    pc_n        = PC_F;
    pend_n      = pend;
    tgt_n       = tgt_q;
    req         = 1'b0;
    ifid_ld     = 1'b0;
    bubble      = 1'b0;
    ifid_ir     = imem_rdata;
    ifid_pc4    = pc_plus4;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    ifid_exc    = 1'b0;
`endif
    case (state)
      FETCH: begin
        req = !misalign;
        if (misalign) begin
          if (!stall_i) begin
            ifid_ld = 1'b1;
            ifid_ir = NOP_WORD;
            pc_n    = adv_pc;
            pend_n  = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
            ifid_exc = 1'b1;
`endif
          end
        end else if (ack) begin
          pc_n   = adv_pc;
          pend_n = 1'b0;
          if (stall_i) begin
            skid_load = 1'b1;
            state_n   = BUF;
          end else begin
            ifid_ld = 1'b1;
          end
        end else if (!stall_i) begin
          bubble = 1'b1;
          if (redir) begin
            pend_n = 1'b1;
            tgt_n  = NPC_i;
          end
        end
      end
      BUF: begin
        if (!stall_i && skid_full) begin
          skid_unload = 1'b1;
          ifid_ld     = 1'b1;
          ifid_ir     = skid_ir;
          ifid_pc4    = skid_pc4;
          state_n     = FETCH;
          if (redir) pc_n = NPC_i;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= FETCH;
      PC_F    <= RESET_PC;
      pend    <= 1'b0;
      tgt_q   <= 32'h0;
      IR_D    <= 32'h0;
      PC4_D   <= 32'h0;
      valid_D <= 1'b0;
    end else begin
      state <= state_n;
      PC_F  <= pc_n;
      pend  <= pend_n;
      tgt_q <= tgt_n;
      if (ifid_ld) begin
        IR_D    <= ifid_ir;
        PC4_D   <= ifid_pc4;
        valid_D <= 1'b1;
      end else if (bubble) begin
        valid_D <= 1'b0;
      end
    end
  end

`ifdef FETCH_ALIGN_CHK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     exc_adel_D <= 1'b0;
    else if (ifid_ld) exc_adel_D <= ifid_exc;
  end
`else
  assign exc_adel_D = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the P6 pipeline. It owns the PC register, issues word fetches to instruction memory over a req/ack handshake, and drives the IF/ID pipeline register (IR_D, PC4_D) consumed by the D-stage next-PC and branch logic. It applies the next-PC redirect from D with MIPS delay-slot semantics and holds under hazard stalls without dropping an in-flight fetch.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- clk  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- stall_i  in  1  hazard-unit stall: hold PC and IF/ID
- redirect_i  in  1  D-stage jump or taken branch; NPC_i valid
- NPC_i  in  32  target from D-stage next-PC logic
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, word-aligned
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- PC_F  out  32  current fetch PC
- IR_D  out  32  IF/ID instruction
- PC4_D  out  32  IF/ID PC+4
- valid_D  out  1  IF/ID holds a real instruction (0 = bubble)
- exc_adel_D  out  1  misaligned-fetch flag (FETCH_ALIGN_CHK_EN only; otherwise tied 0)

## Operation
- A fetch completes on a cycle with imem_req && imem_ack. Ack may arrive in the same cycle as req or later.
- Once imem_req is raised, it stays high with imem_addr stable until ack. Stall never withdraws it.
- States:
  - FETCH: imem_req=1, imem_addr={PC_F[31:2],2'b00}.
    - Ack and !stall: IR_D<=imem_rdata, PC4_D<=PC_F+4, valid_D<=1, PC advances.
    - Ack and stall: capture {rdata, PC_F+4} into the skid buffer, PC advances, go BUF.
    - No ack and !stall: valid_D<=0 (bubble).
    - No ack and stall: IF/ID held.
  - BUF: imem_req=0. While stall, hold. When !stall: IF/ID<=buffer, valid_D<=1, go FETCH.
- PC advance: PC<=PC_F+4, unless a redirect target applies.
- Redirect is honoured only on cycles with !stall, which are D-advance cycles. The instruction at PC_F is the delay slot.
  - In FETCH with ack this cycle, or in BUF: PC<=NPC_i.
  - In FETCH without ack: latch tgt_q<=NPC_i and set pend=1. The next completing fetch loads PC<=tgt_q and clears pend.
- Redirect while stall=1 is ignored. D re-presents it.
- Arithmetic is 32-bit modulo. PC_F+4 at 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset (async assert, sync release): PC_F=RESET_PC, IR_D=0, PC4_D=0, valid_D=0, exc_adel_D=0, state FETCH, pend=0. imem_req is forced to 0 while reset_n is low.
- First imem_req occurs in the first cycle after reset release.
- Zero-wait memory gives one instruction per cycle, with IR_D valid the cycle after ack.
- Reset mid-fetch abandons the request. Memory must tolerate req dropping under reset.

## Configuration
- FETCH_ALIGN_CHK_EN defined:
  - If PC_F[1:0]!=0, no request is issued.
  - Next !stall cycle: IR_D<=32'h0, valid_D<=1, exc_adel_D<=1, PC advances by +4 from PC_F.
  - exc_adel_D clears on the next IF/ID load.
- Undefined: PC_F[1:0] are ignored, the address is forced word-aligned, and exc_adel_D is tied to 0.

## Structure
- cpu_defs_pkg holds RESET_PC default, NOP word (32'h0), and the fetch-state enum {FETCH, BUF}.
- Sub-module fetch_skid holds the one-entry instruction/PC4 skid buffer with load/unload/full. The PC, pend/tgt_q and FSM stay in fetch_unit.

## Test plan
- Reset, then zero-wait ack every cycle: imem_addr 3000, 3004, 3008. IR_D follows rdata one cycle later, and valid_D=1 from the 2nd cycle.
- Ack delayed 2 cycles at 3004: req and addr held at 3004 for 3 cycles, valid_D=0 for 2 cycles, then IR_D=word@3004.
- Ack at 3008 with stall=1 for 3 cycles: IF/ID unchanged, req=0 after ack. On stall drop, IR_D=word@3008, and the next req is 300C.
- Branch in D with redirect_i=1, NPC_i=3040, delay-slot ack same cycle: the next imem_addr is 3040.
- Redirect with NPC_i=3100 while the delay-slot fetch is pending 2 cycles: after ack, imem_addr=3100 (not +4), and pend clears.
- With FETCH_ALIGN_CHK_EN, NPC_i=3042: no req at 3042, IR_D=0, exc_adel_D=1, next addr 3046→fetch forced handled per flag.
